// File: rtl/sync_latch_bank.sv
// sync_latch_bank: a bank of CH independent synchronous latch channels.
// Each channel models one of the 1801 asynchronous latch cells. A channel
// runs as a gated D latch when mode=0 and as a clocked RS latch when mode=1.
// The S&R conflict case resolves to reset-wins, set-wins or NOR behaviour,
// depending on PRIO. In NOR behaviour both q and qn drop low.
// q/qn then pass through DLY extra register stages, so FPGA models of
// gate-array netlists keep the cell delay of the original cells.
// Optional feature macro: SYNC_LATCH_BANK_TRACE_EN. When it is defined, the
// block adds an 8-bit saturating count of the cycles in which any chg bit is high.
module sync_latch_bank #(
    parameter int CH   = 8,
    parameter int DLY  = 0,
    parameter int PRIO = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] mode,
    input  logic [CH-1:0] c,
    input  logic [CH-1:0] d,
    input  logic [CH-1:0] s,
    input  logic [CH-1:0] r,
    input  logic          clr,
    input  logic          cfl_clr,
    output logic [CH-1:0] q,
    output logic [CH-1:0] qn,
    output logic [CH-1:0] chg,
`ifdef SYNC_LATCH_BANK_TRACE_EN
    output logic [7:0]    trace_cnt,
`endif
    output logic [CH-1:0] cfl
);

    // Parameter values outside the supported range stop elaboration.
    generate
        if (CH < 1 || CH > 32) begin : g_badCh
            $error("sync_latch_bank: CH must be in 1..32");
        end
        if (DLY < 0 || DLY > 7) begin : g_badDly
            $error("sync_latch_bank: DLY must be in 0..7");
        end
        if (PRIO < 0 || PRIO > 2) begin : g_badPrio
            $error("sync_latch_bank: PRIO must be 0, 1 or 2");
        end
    endgenerate

    logic [CH-1:0] st_q;
    logic [CH-1:0] st_d;
    logic [CH-1:0] forced_d;
    logic [CH-1:0] rawQ_d;
    logic [CH-1:0] rawQn_d;
    logic [CH-1:0] qNext_d;
    logic [CH-1:0] chg_q;
    logic [CH-1:0] cfl_q;
    logic [CH-1:0] cfl_d;
    logic [CH-1:0] pipeQ_q  [DLY+1];
    logic [CH-1:0] pipeQn_q [DLY+1];

    // Next latch state per channel. clr beats every data input. In NOR
    // behaviour (PRIO=2), S&R keeps the stored state and marks the channel
    // as forced-low for this cycle only.
    always_comb begin
        st_d     = st_q;
        forced_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (clr) begin
                st_d[i] = 1'b0;
            end else if (c[i]) begin
                if (!mode[i]) begin
                    st_d[i] = d[i];
                end else begin
                    unique case ({s[i], r[i]})
                        2'b10:   st_d[i] = 1'b1;
                        2'b01:   st_d[i] = 1'b0;
                        2'b11: begin
                            if (PRIO == 0) begin
                                st_d[i] = 1'b0;
                            end else if (PRIO == 1) begin
                                st_d[i] = 1'b1;
                            end else begin
                                forced_d[i] = 1'b1;
                            end
                        end
                        default: st_d[i] = st_q[i];
                    endcase
                end
            end
        end
        rawQ_d  = st_d & ~forced_d;
        rawQn_d = ~st_d & ~forced_d;
    end

    // Conflict flags are sticky. A new conflict wins over a simultaneous clear.
    always_comb begin
        cfl_d = (cfl_q & ~{CH{cfl_clr}}) | (mode & c & s & r);
    end

    // Latch state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    // Output delay line. Stage 0 captures the raw outputs at the sampling
    // edge. Reset flushes every stage to the idle q=0 / qn=1 pattern.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int j = 0; j <= DLY; j++) begin
                pipeQ_q[j]  <= '0;
                pipeQn_q[j] <= '1;
            end
        end else begin
            pipeQ_q[0]  <= rawQ_d;
            pipeQn_q[0] <= rawQn_d;
            for (int j = 1; j <= DLY; j++) begin
                pipeQ_q[j]  <= pipeQ_q[j-1];
                pipeQn_q[j] <= pipeQn_q[j-1];
            end
        end
    end

    // Select the value that the final q stage will load at the next edge.
    // chg compares this value with the current q.
    generate
        if (DLY == 0) begin : g_noDelay
            assign qNext_d = rawQ_d;
        end else begin : g_delay
            assign qNext_d = pipeQ_q[DLY-1];
        end
    endgenerate

    // Change pulse and conflict flag registers. Both update at the same
    // edge as q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chg_q <= '0;
            cfl_q <= '0;
        end else begin
            chg_q <= qNext_d ^ pipeQ_q[DLY];
            cfl_q <= cfl_d;
        end
    end

    assign q   = pipeQ_q[DLY];
    assign qn  = pipeQn_q[DLY];
    assign chg = chg_q;
    assign cfl = cfl_q;

`ifdef SYNC_LATCH_BANK_TRACE_EN
    logic [7:0] traceCnt_q;
    logic [7:0] traceCnt_d;

    // Count the cycles that show any change pulse. The count stops at 255,
    // and clr restarts it.
    always_comb begin
        traceCnt_d = traceCnt_q;
        if (clr) begin
            traceCnt_d = 8'd0;
        end else if ((|chg_q) && (traceCnt_q != 8'hFF)) begin
            traceCnt_d = traceCnt_q + 8'd1;
        end
    end

    // Trace counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            traceCnt_q <= 8'd0;
        end else begin
            traceCnt_q <= traceCnt_d;
        end
    end

    assign trace_cnt = traceCnt_q;
`endif

endmodule

// File: doc/sync_latch_bank.md
Name: sync_latch_bank

Overview:
- Synthesizable, single-clock successor to the 1801 library's asynchronous latch cells: NOR RS latch, clocked RS latch and gated D latch.
- Bank of CH independent channels; each channel is run-time selectable between gated-D and clocked-RS behaviour.
- Configurable dominance for the forbidden S&R case, including the NOR-latch "both outputs low" mode.
- Programmable propagation delay in clock cycles, for timing-faithful FPGA models of gate-array netlists.

Parameters:
- CH, 8, number of latch channels (1..32).
- DLY, 0, extra output pipeline stages emulating cell delay (0..7); DLY>7 is an elaboration error.
- PRIO, 0, S&R conflict resolution in RS mode: 0 = reset wins, 1 = set wins, 2 = NOR mode.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active low.
- mode  in  CH  per channel: 0 = gated D, 1 = clocked RS.
- c  in  CH  per-channel gate/clock-enable (the c1 input of the cells).
- d  in  CH  data input, D mode.
- s  in  CH  set input, RS mode.
- r  in  CH  reset input, RS mode.
- clr  in  1  synchronous global clear of latch state.
- cfl_clr  in  1  clears conflict flags.
- q  out  CH  latch output.
- qn  out  CH  complementary output; not always ~q when PRIO=2.
- chg  out  CH  one-cycle pulse when q changes.
- cfl  out  CH  sticky S&R conflict flag.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State st=0 and all pipeline stages clear; q=0, qn=all ones, chg=0, cfl=0.
  - Reset overrides every other input.
  - Reset mid-operation discards all in-flight pipeline contents.
- Per-channel next state, sampled at each rising edge:
  - clr=1: st<=0 on all channels. Has priority over c/d/s/r; does not touch cfl.
  - c=0: hold.
  - D mode, c=1: st<=d (synchronous transparency).
  - RS mode, c=1:
    - s&~r: st<=1.
    - r&~s: st<=0.
    - ~s&~r: hold.
    - s&r, PRIO=0: st<=0.
    - s&r, PRIO=1: st<=1.
    - s&r, PRIO=2: st holds; channel marked "forced-low" this cycle.
- Raw outputs:
  - q_raw = st.
  - qn_raw = ~st, except qn_raw = 0 when forced-low.
  - With PRIO=2 and forced-low, q_raw = 0 and qn_raw = 0 (NOR latch with both inputs active).
  - On release of s&r, the channel returns to the held st.
- Latency:
  - q_raw/qn_raw are registered at the sampling edge.
  - q/qn pass through DLY further register stages.
  - Input sampled at edge k appears on q/qn after edge k+DLY.
  - DLY=0: visible right after edge k.
- Mode switch takes effect at the edge where the new mode is sampled; st is retained across the switch.
- chg: registered at the same edge q updates; chg[i]=1 for exactly the cycle in which q[i] differs from its previous value.
- cfl:
  - cfl[i] set at any edge with mode=1, c=1, s=1, r=1.
  - Cleared by cfl_clr=1; if set and clear occur together, set wins.
  - Not delayed by DLY.
- Channels are fully independent; no cross-channel interaction except clr and cfl_clr.

Optional Feature:
- Macro SYNC_LATCH_BANK_TRACE_EN.
- Defined:
  - Adds output trace_cnt (8 bits), a saturating count of cycles in which any chg bit is 1.
  - Saturates at 255; reset and clr both zero it.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset/clr: reset_n=0 one edge -> q=0x00, qn=0xFF, cfl=0x00, chg=0x00. Set q=0xA5, then clr=1 with c=0xFF, s=0xFF, r=0x00 -> q=0x00.
- D mode, CH=8, DLY=0: mode=0x00, c=0x0F, d=0xFF -> q=0x0F after the same edge; chg=0x0F for one cycle; c=0x00, d=0x00 -> q holds 0x0F.
- RS priority: mode=0xFF, c=0x01, s=0x01, r=0x01.
  - PRIO=0 -> q[0]=0.
  - PRIO=1 -> q[0]=1.
  - Any PRIO -> cfl[0]=1, and it stays 1 until cfl_clr.
- PRIO=2 from q[0]=1: s=r=1 -> q[0]=0, qn[0]=0; release to s=r=0 -> q[0]=1, qn[0]=0, chg[0] pulses on each transition.
- DLY=3: d=1, c=1 sampled at edge k -> q changes after edge k+3; reset_n=0 at edge k+1 -> q stays 0, no chg pulse.
- With SYNC_LATCH_BANK_TRACE_EN: toggle d[0] with c[0]=1 every cycle for 300 cycles -> trace_cnt=255.
